// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// on hazards and branch flushes, and saturating stall/flush event counters.
module id_ex_hazard_reg #(
  parameter int ADDRESS_W = 5,
  parameter int DATA_W    = 32,
  parameter int CTRL_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [ADDRESS_W-1:0] id_rs1,
  input  logic [ADDRESS_W-1:0] id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [ADDRESS_W-1:0] id_rd,
  input  logic                 id_reg_wrt_en,
  input  logic                 id_mem_rd,
  input  logic [DATA_W-1:0]    id_rd1,
  input  logic [DATA_W-1:0]    id_rd2,
  input  logic [DATA_W-1:0]    id_imm,
  input  logic [DATA_W-1:0]    id_pc,
  input  logic [CTRL_W-1:0]    id_ctrl,
  input  logic                 ex_flush,
  input  logic                 ext_stall,
  output logic                 stall_if_id,
  output logic                 ex_valid,
  output logic                 ex_reg_wrt_en,
  output logic                 ex_mem_rd,
  output logic [ADDRESS_W-1:0] ex_rs1,
  output logic [ADDRESS_W-1:0] ex_rs2,
  output logic [ADDRESS_W-1:0] ex_rd,
  output logic [DATA_W-1:0]    ex_rd1,
  output logic [DATA_W-1:0]    ex_rd2,
  output logic [DATA_W-1:0]    ex_imm,
  output logic [DATA_W-1:0]    ex_pc,
  output logic [CTRL_W-1:0]    ex_ctrl,
  output logic [CNT_W-1:0]     lu_stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  // Flow semantics: id_valid qualifies the ID slot; ex_valid qualifies the EX
  // slot. stall_if_id=1 means ID must present the same instruction again next
  // cycle. A bubble clears every field that forwarding or hazard logic matches
  // on (valid, write enable, load flag, register addresses, control), so a
  // bubble can never alias a real producer. Data fields are left untouched.

  logic                 valid_q, valid_d;
  logic                 wrt_q, wrt_d;
  logic                 mem_rd_q, mem_rd_d;
  logic [ADDRESS_W-1:0] rs1_q, rs1_d;
  logic [ADDRESS_W-1:0] rs2_q, rs2_d;
  logic [ADDRESS_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0]    rd1_q, rd1_d;
  logic [DATA_W-1:0]    rd2_q, rd2_d;
  logic [DATA_W-1:0]    imm_q, imm_d;
  logic [DATA_W-1:0]    pc_q, pc_d;
  logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
  logic [CNT_W-1:0]     lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0]     fl_cnt_q, fl_cnt_d;
  logic                 lu;

  // Load-use detection against the load currently sitting in EX.
  always_comb begin
    lu = valid_q && mem_rd_q && (rd_q != '0) && id_valid &&
         ((id_rs1_used && (id_rs1 == rd_q)) || (id_rs2_used && (id_rs2 == rd_q)));
  end

  // Stall IF/ID on a downstream freeze, or on a load-use not overridden by a flush.
  always_comb begin
    stall_if_id = ext_stall || (!ex_flush && lu);
  end

  // Next-state selection: freeze > flush bubble > load-use bubble > capture.
  always_comb begin
    valid_d  = valid_q;
    wrt_d    = wrt_q;
    mem_rd_d = mem_rd_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    imm_d    = imm_q;
    pc_d     = pc_q;
    ctrl_d   = ctrl_q;
    lu_cnt_d = lu_cnt_q;
    fl_cnt_d = fl_cnt_q;
    if (ext_stall) begin
      // hold everything
    end else if (ex_flush || lu) begin
      valid_d  = 1'b0;
      wrt_d    = 1'b0;
      mem_rd_d = 1'b0;
      rs1_d    = '0;
      rs2_d    = '0;
      rd_d     = '0;
      ctrl_d   = '0;
      if (ex_flush) begin
        fl_cnt_d = (fl_cnt_q == '1) ? fl_cnt_q : fl_cnt_q + CNT_W'(1);
      end else begin
        lu_cnt_d = (lu_cnt_q == '1) ? lu_cnt_q : lu_cnt_q + CNT_W'(1);
      end
    end else begin
      valid_d  = id_valid;
      wrt_d    = id_valid && id_reg_wrt_en;
      mem_rd_d = id_valid && id_mem_rd;
      rs1_d    = id_rs1;
      rs2_d    = id_rs2;
      rd_d     = id_rd;
      rd1_d    = id_rd1;
      rd2_d    = id_rd2;
      imm_d    = id_imm;
      pc_d     = id_pc;
      ctrl_d   = id_ctrl;
    end
  end

  // ID/EX state and counters, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      wrt_q    <= 1'b0;
      mem_rd_q <= 1'b0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
      ctrl_q   <= '0;
      lu_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      valid_q  <= valid_d;
      wrt_q    <= wrt_d;
      mem_rd_q <= mem_rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      imm_q    <= imm_d;
      pc_q     <= pc_d;
      ctrl_q   <= ctrl_d;
      lu_cnt_q <= lu_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_reg_wrt_en = wrt_q;
  assign ex_mem_rd     = mem_rd_q;
  assign ex_rs1        = rs1_q;
  assign ex_rs2        = rs2_q;
  assign ex_rd         = rd_q;
  assign ex_rd1        = rd1_q;
  assign ex_rd2        = rd2_q;
  assign ex_imm        = imm_q;
  assign ex_pc         = pc_q;
  assign ex_ctrl       = ctrl_q;
  assign lu_stall_cnt  = lu_cnt_q;
  assign flush_cnt     = fl_cnt_q;

endmodule

// File: doc/id_ex_hazard_reg.md
# id_ex_hazard_reg

ID/EX pipeline register with integrated load-use hazard detection. It captures decoded operands, register-file read data, immediate, PC and control from the ID stage. It presents them to EX, where ex_rs1/ex_rs2/ex_rd and ex_reg_wrt_en feed the operand forwarding unit. It also generates the IF/ID stall, inserts bubbles on load-use hazards and branch flushes, and keeps saturating stall/flush event counters.

## Interface
Parameters:
- ADDRESS_W, 5, register address width
- DATA_W, 32, datapath width
- CTRL_W, 8, opaque EX/MEM/WB control bundle width
- CNT_W, 16, event counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  ADDRESS_W  source register addresses
- id_rs1_used, id_rs2_used  in  1  instruction actually reads rs1/rs2
- id_rd  in  ADDRESS_W  destination register
- id_reg_wrt_en  in  1  instruction writes rd
- id_mem_rd  in  1  instruction is a load
- id_rd1, id_rd2, id_imm, id_pc  in  DATA_W  read data, immediate, PC
- id_ctrl  in  CTRL_W  remaining control bundle
- ex_flush  in  1  branch/jump taken, resolved in EX this cycle
- ext_stall  in  1  downstream (data memory) not ready; freeze pipeline
- stall_if_id  out  1  hold PC and IF/ID register this cycle
- ex_valid, ex_reg_wrt_en, ex_mem_rd  out  1  registered copies
- ex_rs1, ex_rs2, ex_rd  out  ADDRESS_W  registered addresses
- ex_rd1, ex_rd2, ex_imm, ex_pc  out  DATA_W  registered data
- ex_ctrl  out  CTRL_W  registered control bundle
- lu_stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- Load-use hazard (combinational): lu = ex_valid & ex_mem_rd & (ex_rd != 0) & id_valid & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd)).
- Bubble means ex_valid=0, ex_reg_wrt_en=0, ex_mem_rd=0, ex_rd=0, ex_rs1=0, ex_rs2=0, ex_ctrl=0. ex_rd1/ex_rd2/ex_imm/ex_pc hold their previous values. A bubble therefore never matches in forwarding.
- Per-cycle action, strict priority:
  1. ext_stall=1: hold all ID/EX fields; stall_if_id=1; counters hold.
  2. ex_flush=1: load a bubble; stall_if_id=0 (IF/ID flush is handled upstream); flush_cnt += 1.
  3. lu=1: load a bubble; stall_if_id=1; lu_stall_cnt += 1.
  4. Otherwise: capture all id_* fields, with ex_valid=id_valid; stall_if_id=0.
- id_valid=0 in case 4 captures the fields as given, but ex_valid=0 and ex_reg_wrt_en/ex_mem_rd are forced to 0.
- Counters saturate at all-ones and never wrap.
- A load-use hazard lasts exactly one cycle, because the next cycle EX holds a bubble (ex_valid=0).
- ex_flush and lu in the same cycle: flush wins, no stall, and only flush_cnt increments.

## Timing
- All ID/EX fields and counters update on the rising edge of clk.
- stall_if_id is combinational from current ID/EX state, id_* inputs, ex_flush and ext_stall. It is valid in the same cycle and contains no register.
- Latency: ID to EX is 1 cycle. A load-use pair costs exactly 1 bubble cycle.
- Reset (rst_n=0, asynchronous): every registered output goes to 0, including counters and ex_valid.
- During reset, stall_if_id = ext_stall, because lu=0 while ex_valid=0.
- Reset mid-stall drops the in-flight instruction. After reset the first edge captures normally.
- ext_stall held for N cycles freezes the outputs for N edges. A hazard pending under ext_stall is re-evaluated once the stall releases.

## Test plan
- Reset: drive rst_n=0 asynchronously mid-cycle -> all ex_* and counters read 0 immediately; stall_if_id=0 with ext_stall=0.
- Normal capture: id_valid=1, rs1=3, rs2=4, rd=5, id_rd1=0x11, id_imm=0x20, no hazards -> next cycle ex_rs1=3, ex_rd=5, ex_rd1=0x11, ex_valid=1.
- Load-use:
  - Setup: EX holds a load with rd=7; ID instruction has rs2=7, rs2_used=1.
  - Same cycle: stall_if_id=1.
  - Next edge: bubble loaded (ex_rd=0, ex_valid=0), lu_stall_cnt=1.
  - Following edge: the instruction is captured with ex_rs2=7.
- Unused source and x0: load rd=7 with rs1_used=0/rs1=7 -> no stall. A load with rd=0 -> no stall.
- Flush priority: ex_flush=1 together with a load-use match -> stall_if_id=0, bubble loaded, flush_cnt=1, lu_stall_cnt unchanged.
- ext_stall and saturation:
  - ext_stall=1 for 3 cycles -> outputs unchanged, stall_if_id=1.
  - Preload a counter at 0xFFFF and trigger a flush -> it stays at 0xFFFF.
